claa_pipe_add: RTL and testbench
================================

# claa_pipe_add

Two-stage pipelined carry-lookahead adder/subtractor with valid/ready handshakes on both sides. Stage 1 registers per-bit and per-group propagate/generate terms. Stage 2 resolves group carries through a group-level lookahead, then forms bit carries and the sum. It sits directly downstream of operand selection and feeds the ALU result mux, consuming the group propagate/generate terms it builds itself.

## Interface
- `WIDTH`, 32, operand and sum width; must be a multiple of `GROUP`.
- `GROUP`, 4, bits per lookahead group; `NG = WIDTH/GROUP` groups.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  reset; asynchronous assert, active-low.
- `s_valid_i`  in  1  input transaction valid.
- `s_ready_o`  out  1  block accepts the input this cycle.
- `a_i`  in  WIDTH  operand A.
- `b_i`  in  WIDTH  operand B.
- `c_i`  in  1  carry-in when adding; borrow-in when subtracting.
- `sub_i`  in  1  1 = compute A − B − c_i.
- `m_valid_o`  out  1  result valid.
- `m_ready_i`  in  1  downstream accepts the result.
- `sum_o`  out  WIDTH  result.
- `c_o`  out  1  raw carry-out of the MSB; when subtracting, borrow = ~c_o.
- `v_o`  out  1  signed overflow (only with `CLAA_PIPE_FLAGS_EN`).
- `z_o`  out  1  result == 0 (only with `CLAA_PIPE_FLAGS_EN`).

## Operation
- Effective inputs: B' = `sub_i` ? ~`b_i` : `b_i`; cin = `c_i` ^ `sub_i`.
- Stage 1 is captured on accept (`s_valid_i & s_ready_o`). It registers:
  - p = A ^ B' and g = A & B' (per bit);
  - group pg[k] = &p over group k, and group gg[k] = lookahead generate of group k;
  - cin, plus the MSBs of A and B' (for overflow).
- Stage 2 is captured when stage 1 is valid and stage 2 is empty or draining:
  - group carries: C[0] = cin, C[k+1] = gg[k] | (pg[k] & C[k]);
  - in-group bit carries follow the same recurrence seeded by C[k];
  - sum = p ^ carry-vector; `c_o` = C[NG].
- `v_o` = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]).
- `z_o` = ~|sum.
- Stage valid bits: v1 and v2. Stage 2 drives the `m_*` outputs directly from its registers.
- Each stage holds its contents while blocked; no data is dropped or duplicated, and order is preserved.
- `WIDTH % GROUP != 0` is an elaboration error (`$error`).

## Timing
- Latency: 2 cycles from accept to `m_valid_o`. Throughput: 1 transaction per cycle when `m_ready_i` = 1.
- `s_ready_o` = ~v1 | ~v2 | `m_ready_i`. The combinational path from `m_ready_i` to `s_ready_o` is permitted.
- Stage 2 advance: adv2 = v1 & (~v2 | `m_ready_i`).
- v2 next = adv2 | (v2 & ~`m_ready_i`).
- v1 next = accept | (v1 & ~adv2).
- Simultaneous accept and adv2: stage 1 loads the new operands while the old ones move to stage 2.
- Full: v1 = v2 = 1 with `m_ready_i` = 0 gives `s_ready_o` = 0. Empty: `m_valid_o` = 0, and `s_ready_o` = 1.
- `m_valid_o` may rise independent of `m_ready_i`. Once high, `m_valid_o` and the payload stay stable until the handshake completes.
- Reset (asynchronous, immediate, including mid-transaction):
  - v1 = v2 = 0;
  - `m_valid_o`, `sum_o`, `c_o`, `v_o`, `z_o` = 0;
  - `s_ready_o` = 1 combinationally.
  - In-flight transactions are discarded. No stale result appears after release.

## Configuration
- `CLAA_PIPE_FLAGS_EN` defined:
  - `v_o` and `z_o` ports exist;
  - stage 1 carries the operand MSBs;
  - stage 2 registers the flags alongside `sum_o`.
- Not defined:
  - ports are absent and no flag logic or MSB registers exist;
  - sum, carry and handshake behaviour are identical.

## Structure
- Package `claa_pkg` holds:
  - `claa_s1_t` struct (p, g, pg, gg, cin, msb_a, msb_b);
  - `claa_flags_t` struct (v, z);
  - localparams `CLAA_DEF_WIDTH` = 32 and `CLAA_DEF_GROUP` = 4.
- One sub-module: `claa_pipe_slot`, a parameterised payload register with a valid bit, load/hold control and asynchronous active-low clear. It is instantiated once per stage.

## Test plan
All scenarios use WIDTH=32, GROUP=4.
- `a_i`=0xFFFFFFFF, `b_i`=1, `c_i`=0, `sub_i`=0 -> 2 cycles later `sum_o`=0, `c_o`=1, `z_o`=1, `v_o`=0.
- `a_i`=5, `b_i`=7, `sub_i`=1, `c_i`=0 -> `sum_o`=0xFFFFFFFE, `c_o`=0 (borrow), `v_o`=0.
- `a_i`=0x7FFFFFFF, `b_i`=1, add -> `sum_o`=0x80000000, `v_o`=1, `c_o`=0; `a_i`=0x0000000F, `b_i`=1, `c_i`=1 -> 0x00000011 (group carry crossing).
- Back-to-back inputs 1+1, 2+2, 3+3 with `m_ready_i`=0 for 4 cycles:
  - `s_ready_o` falls after the second accept;
  - after release, outputs are 2, 4, 6 in order on consecutive cycles.
- Reset mid-operation: v1 = v2 = 1, then `rst_n_i`=0 -> `m_valid_o`=0 and `sum_o`=0 at once; after release, no `m_valid_o` until a new accept.
- 10k random operands with random `sub_i`/`c_i` and random `m_ready_i` stalls -> every result matches the reference model {`c_o`, `sum_o`} = A + B' + cin, with no loss or reordering.

Source files
------------

// File: rtl/claa_pkg.sv
// Shared types and default sizing for the two-stage carry-lookahead adder/subtractor.
package claa_pkg;

  localparam int CLAA_DEF_WIDTH = 32;
  localparam int CLAA_DEF_GROUP = 4;

  // Stage-1 layout at the default sizing; the top rebuilds it from its own parameters.
  typedef struct packed {
    logic [CLAA_DEF_WIDTH-1:0]                p;
    logic [CLAA_DEF_WIDTH-1:0]                g;
    logic [CLAA_DEF_WIDTH/CLAA_DEF_GROUP-1:0] pg;
    logic [CLAA_DEF_WIDTH/CLAA_DEF_GROUP-1:0] gg;
    logic                                     cin;
    logic                                     msb_a;
    logic                                     msb_b;
  } claa_s1_t;

  typedef struct packed {
    logic v;
    logic z;
  } claa_flags_t;

endpackage

// File: rtl/claa_pipe_slot.sv
// One pipeline slot: payload register plus valid bit, with load/unload control
// and asynchronous active-low clear of both valid and payload.
module claa_pipe_slot #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         unload,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // Load wins over unload so a slot that drains and refills in one cycle stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/claa_pipe_add.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Define CLAA_PIPE_FLAGS_EN to add the signed-overflow (v_o) and zero (z_o) flags.
module claa_pipe_add
  import claa_pkg::*;
#(
  parameter int WIDTH = CLAA_DEF_WIDTH,
  parameter int GROUP = CLAA_DEF_GROUP
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  input  logic             sub_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             c_o
`ifdef CLAA_PIPE_FLAGS_EN
  ,
  output logic             v_o,
  output logic             z_o
`endif
);

  localparam int NG = WIDTH / GROUP;

  if (WIDTH % GROUP != 0) begin : g_width_check
    $error("claa_pipe_add: WIDTH (%0d) must be a multiple of GROUP (%0d)", WIDTH, GROUP);
  end

  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [NG-1:0]    pg;
    logic [NG-1:0]    gg;
    logic             cin;
`ifdef CLAA_PIPE_FLAGS_EN
    logic             msb_a;
    logic             msb_b;
`endif
  } s1_t;

  typedef struct packed {
`ifdef CLAA_PIPE_FLAGS_EN
    claa_flags_t      flags;
`endif
    logic             cout;
    logic [WIDTH-1:0] sum;
  } s2_t;

  function automatic logic group_generate(input logic [GROUP-1:0] p,
                                          input logic [GROUP-1:0] g);
    logic gen;
    gen = 1'b0;
    for (int i = 0; i < GROUP; i++) gen = g[i] | (p[i] & gen);
    return gen;
  endfunction

  function automatic logic [NG:0] group_carry_chain(input logic [NG-1:0] pg,
                                                    input logic [NG-1:0] gg,
                                                    input logic          cin);
    logic [NG:0] c;
    c[0] = cin;
    for (int k = 0; k < NG; k++) c[k+1] = gg[k] | (pg[k] & c[k]);
    return c;
  endfunction

  // Carry into each bit of a group, seeded by that group's incoming carry.
  function automatic logic [GROUP-1:0] bit_carries(input logic [GROUP-1:0] p,
                                                   input logic [GROUP-1:0] g,
                                                   input logic             seed);
    logic [GROUP-1:0] c;
    logic             run;
    run = seed;
    for (int i = 0; i < GROUP; i++) begin
      c[i] = run;
      run  = g[i] | (p[i] & run);
    end
    return c;
  endfunction

  logic             accept;
  logic             adv2;
  logic             v1;
  logic             v2;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] g_in;
  s1_t              s1_d;
  s1_t              s1_q;
  s2_t              s2_d;
  s2_t              s2_q;
  logic [NG:0]      grp_c;
  logic [WIDTH-1:0] bit_c;

  assign s_ready_o = ~v1 | ~v2 | m_ready_i;
  assign accept    = s_valid_i & s_ready_o;
  assign adv2      = v1 & (~v2 | m_ready_i);

  assign b_eff = sub_i ? ~b_i : b_i;
  assign p_in  = a_i ^ b_eff;
  assign g_in  = a_i & b_eff;

  always_comb begin
    s1_d     = '0;
    s1_d.p   = p_in;
    s1_d.g   = g_in;
    s1_d.cin = c_i ^ sub_i;
    for (int k = 0; k < NG; k++) begin
      s1_d.pg[k] = &p_in[k*GROUP +: GROUP];
      s1_d.gg[k] = group_generate(p_in[k*GROUP +: GROUP], g_in[k*GROUP +: GROUP]);
    end
`ifdef CLAA_PIPE_FLAGS_EN
    s1_d.msb_a = a_i[WIDTH-1];
    s1_d.msb_b = b_eff[WIDTH-1];
`endif
  end

  // Stage 2 resolves group carries first, then ripples only within each group.
  always_comb begin
    s2_d  = '0;
    bit_c = '0;
    grp_c = group_carry_chain(s1_q.pg, s1_q.gg, s1_q.cin);
    for (int k = 0; k < NG; k++) begin
      bit_c[k*GROUP +: GROUP] = bit_carries(s1_q.p[k*GROUP +: GROUP],
                                            s1_q.g[k*GROUP +: GROUP], grp_c[k]);
    end
    s2_d.sum  = s1_q.p ^ bit_c;
    s2_d.cout = grp_c[NG];
`ifdef CLAA_PIPE_FLAGS_EN
    s2_d.flags.v = (s1_q.msb_a == s1_q.msb_b) & (s2_d.sum[WIDTH-1] != s1_q.msb_a);
    s2_d.flags.z = ~|s2_d.sum;
`endif
  end

  claa_pipe_slot #(.W($bits(s1_t))) u_slot1 (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .load   (accept),
    .unload (adv2),
    .d      (s1_d),
    .valid  (v1),
    .q      (s1_q)
  );

  claa_pipe_slot #(.W($bits(s2_t))) u_slot2 (
    .clk    (clk_i),
    .rst_n  (rst_n_i),
    .load   (adv2),
    .unload (m_ready_i),
    .d      (s2_d),
    .valid  (v2),
    .q      (s2_q)
  );

  assign m_valid_o = v2;
  assign sum_o     = s2_q.sum;
  assign c_o       = s2_q.cout;
`ifdef CLAA_PIPE_FLAGS_EN
  assign v_o       = s2_q.flags.v;
  assign z_o       = s2_q.flags.z;
`endif

endmodule

// File: tb/tb_claa_pipe_add.sv
// Scoreboarded bench for claa_pipe_add: directed corner cases, backpressure, reset, random traffic.
// Flag checks are compiled in only when CLAA_PIPE_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_claa_pipe_add;

  localparam int W = 32;

  logic         clk_i     = 1'b0;
  logic         rst_n_i   = 1'b0;
  logic         s_valid_i = 1'b0;
  logic         s_ready_o;
  logic [W-1:0] a_i       = '0;
  logic [W-1:0] b_i       = '0;
  logic         c_i       = 1'b0;
  logic         sub_i     = 1'b0;
  logic         m_valid_o;
  logic         m_ready_i = 1'b0;
  logic [W-1:0] sum_o;
  logic         c_o;
`ifdef CLAA_PIPE_FLAGS_EN
  logic         v_o;
  logic         z_o;
`endif

  typedef struct {
    logic [W-1:0] sum;
    logic         c;
    logic         v;
    logic         z;
  } exp_t;

  exp_t exp_q[$];
  int   total      = 0;
  int   bad        = 0;
  int   ready_mode = 1;

  claa_pipe_add #(.WIDTH(W), .GROUP(4)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .a_i       (a_i),
    .b_i       (b_i),
    .c_i       (c_i),
    .sub_i     (sub_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .sum_o     (sum_o),
    .c_o       (c_o)
`ifdef CLAA_PIPE_FLAGS_EN
    ,
    .v_o       (v_o),
    .z_o       (z_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [W-1:0] sum, input logic c, input logic v, input logic z);
    exp_t e;
    e.sum = sum; e.c = c; e.v = v; e.z = z;
    return e;
  endfunction

  // Reference: plain wide arithmetic for sum/carry, signed range test for overflow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic c, input logic sub);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    longint       s;
    longint       max_pos;
    longint       min_neg;
    int           cin;
    bb      = sub ? ~b : b;
    cin     = (c ^ sub) ? 1 : 0;
    full    = {1'b0, a} + {1'b0, bb} + (W+1)'(cin);
    s       = longint'($signed(a)) + longint'($signed(bb)) + longint'(cin);
    max_pos = (longint'(1) <<< 31) - 1;
    min_neg = -(longint'(1) <<< 31);
    e.sum   = full[W-1:0];
    e.c     = full[W];
    e.v     = (s > max_pos) || (s < min_neg);
    e.z     = (full[W-1:0] == '0);
    return e;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic c, input logic sub, input exp_t e);
    a_i = a; b_i = b; c_i = c; sub_i = sub; s_valid_i = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      @(negedge clk_i);
      if (s_ready_o) begin
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        s_valid_i = 1'b0;
        return;
      end
      @(posedge clk_i); #1;
    end
    total++; bad++;
    $display("[TB] FAIL accept_timeout actual=no_accept required=accept");
    s_valid_i = 1'b0;
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) @(negedge clk_i);
    checkOutput("drain_pending", exp_q.size(), 0);
  endtask

  initial begin : ready_driver
    forever begin
      @(posedge clk_i); #2;
      case (ready_mode)
        0:       m_ready_i = 1'b0;
        1:       m_ready_i = 1'b1;
        default: m_ready_i = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : monitor
    exp_t         e;
    logic         held = 1'b0;
    logic [W+2:0] held_pay = '0;
    logic [W+2:0] pay;
    forever begin
      @(negedge clk_i);
`ifdef CLAA_PIPE_FLAGS_EN
      pay = {v_o, z_o, c_o, sum_o};
`else
      pay = {2'b00, c_o, sum_o};
`endif
      if (!rst_n_i) begin
        held = 1'b0;
      end else begin
        if (held) begin
          checkOutput("hold_valid", m_valid_o, 1);
          checkOutput("hold_payload", pay, held_pay);
        end
        held = 1'b0;
        if (m_valid_o && !m_ready_i) begin
          held     = 1'b1;
          held_pay = pay;
        end
        if (m_valid_o && m_ready_i) begin
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("[TB] FAIL unexpected_result actual=0x%0h required=none", sum_o);
          end else begin
            e = exp_q.pop_front();
            checkOutput("sum", sum_o, e.sum);
            checkOutput("carry", c_o, e.c);
`ifdef CLAA_PIPE_FLAGS_EN
            checkOutput("overflow", v_o, e.v);
            checkOutput("zero", z_o, e.z);
`endif
          end
        end
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    logic [W-1:0] corners [4];
    corners[0] = '0; corners[1] = '1; corners[2] = 32'h7FFF_FFFF; corners[3] = 32'h8000_0000;

    #12;
    checkOutput("reset_m_valid", m_valid_o, 0);
    checkOutput("reset_s_ready", s_ready_o, 1);
    checkOutput("reset_sum", sum_o, 0);
    checkOutput("reset_carry", c_o, 0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checkOutput("idle_m_valid", m_valid_o, 0);
    checkOutput("idle_s_ready", s_ready_o, 1);
    @(posedge clk_i); #1;

    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, mk(32'h0, 1'b1, 1'b0, 1'b1));
    @(negedge clk_i);
    checkOutput("latency_early", m_valid_o, 0);
    @(negedge clk_i);
    checkOutput("latency_due", m_valid_o, 1);
    @(posedge clk_i); #1;

    applyStimulus(32'd5, 32'd7, 1'b0, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    applyStimulus(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0));
    applyStimulus(32'h0000_000F, 32'd1, 1'b1, 1'b0, mk(32'h0000_0011, 1'b0, 1'b0, 1'b0));
    waitDrain();

    ready_mode = 0;
    @(posedge clk_i); #3;
    applyStimulus(32'd1, 32'd1, 1'b0, 1'b0, mk(32'd2, 1'b0, 1'b0, 1'b0));
    applyStimulus(32'd2, 32'd2, 1'b0, 1'b0, mk(32'd4, 1'b0, 1'b0, 1'b0));
    @(negedge clk_i);
    checkOutput("full_s_ready", s_ready_o, 0);
    checkOutput("full_m_valid", m_valid_o, 1);
    @(posedge clk_i); #1;
    fork
      applyStimulus(32'd3, 32'd3, 1'b0, 1'b0, mk(32'd6, 1'b0, 1'b0, 1'b0));
      begin
        repeat (4) @(posedge clk_i);
        #1 ready_mode = 1;
      end
    join
    waitDrain();

    ready_mode = 0;
    @(posedge clk_i); #3;
    ra = $urandom; rb = $urandom;
    applyStimulus(ra, rb, 1'b0, 1'b0, model(ra, rb, 1'b0, 1'b0));
    applyStimulus(rb, ra, 1'b1, 1'b1, model(rb, ra, 1'b1, 1'b1));
    @(negedge clk_i);
    checkOutput("prereset_m_valid", m_valid_o, 1);
    checkOutput("prereset_s_ready", s_ready_o, 0);
    #2 rst_n_i = 1'b0;
    #1;
    checkOutput("midreset_m_valid", m_valid_o, 0);
    checkOutput("midreset_sum", sum_o, 0);
    checkOutput("midreset_carry", c_o, 0);
    checkOutput("midreset_s_ready", s_ready_o, 1);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_n_i = 1'b1;
    ready_mode = 1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk_i);
      checkOutput("no_stale_result", m_valid_o, 0);
    end
    @(posedge clk_i); #1;

    ready_mode = 2;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk_i); #1;
      end
      ra = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      rc = $urandom_range(0, 1) == 1;
      rs = $urandom_range(0, 1) == 1;
      applyStimulus(ra, rb, rc, rs, model(ra, rb, rc, rs));
    end
    ready_mode = 1;
    waitDrain();
    @(negedge clk_i);
    checkOutput("final_idle", m_valid_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
